// File: rtl/fetch_pkg.sv
// Shared constants, entry type and pointer-width helper for the fetch stage.
package fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int PC_INC      = 4;
    localparam int PC_READ_OFS = 8;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic int clog2(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for both the fetch tag queue and the instruction buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int PW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/fetch_buffer_unit.sv
// Fetch stage: PC, credit-limited imem issue, in-order response buffering, redirect flush.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_buffer_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] PerfStallCnt,
    output logic [31:0] PerfFlushCnt
`endif
);

    localparam int PW     = clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int DROP_W = 16;

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              grant;
    logic              keep_rsp;
    logic              pop_instr;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     ibuf_count;
    logic [CW:0]       credit_used;
    logic [WORD_W-1:0] tag_pc;
    fetch_entry_t      ibuf_head;
    logic              ibuf_empty;
    logic              tag_full, tag_empty, ibuf_full;
    logic              unused_flags;

    assign unused_flags = ^{tag_full, tag_empty, ibuf_full};

    // Tag-queue occupancy is the live inflight count: pushed at grant, popped by
    // kept responses, cleared on redirect (stale responses move to drop_q).
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (pc_q),
        .pop       (keep_rsp),
        .flush     (RedirectValid),
        .head      (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (inflight)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (keep_rsp),
        .push_data ({ImemRData, tag_pc}),
        .pop       (pop_instr),
        .flush     (RedirectValid),
        .head      (ibuf_head),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (ibuf_count)
    );

    assign credit_used = {1'b0, inflight} + {1'b0, ibuf_count};
    assign ImemReq     = !reset && !RedirectValid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign ImemAddr    = pc_q;
    assign grant       = ImemReq && ImemGnt;
    assign keep_rsp    = ImemRValid && (drop_q == '0) && !RedirectValid;
    assign InstrValid  = !reset && !ibuf_empty;
    assign pop_instr   = InstrValid && InstrReady && !RedirectValid;
    assign Instr       = ibuf_head.instr;
    assign InstrPC     = ibuf_head.pc;
    assign PCPlus8     = ibuf_head.pc + WORD_W'(PC_READ_OFS);

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (RedirectValid) begin
            pc_d   = RedirectPC & ~32'd3;
            drop_d = drop_q + DROP_W'(inflight) - DROP_W'(ImemRValid);
        end else begin
            if (grant) pc_d = pc_q + WORD_W'(PC_INC);
            if (ImemRValid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (InstrValid && !InstrReady && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (RedirectValid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PerfStallCnt = stall_cnt_q;
    assign PerfFlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Randomized scoreboard bench for fetch_buffer_unit with an epoch-based memory/PC reference model.
module tb_fetch_buffer_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          NCYC     = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PCPlus8;
`ifdef FETCH_PERF_EN
    logic [31:0] PerfStallCnt;
    logic [31:0] PerfFlushCnt;
    logic [31:0] exp_stall, exp_flush;
`endif

    fetch_buffer_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemGnt       (ImemGnt),
        .ImemRValid    (ImemRValid),
        .ImemRData     (ImemRData),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC),
        .InstrValid    (InstrValid),
        .InstrReady    (InstrReady),
        .Instr         (Instr),
        .InstrPC       (InstrPC),
        .PCPlus8       (PCPlus8)
`ifdef FETCH_PERF_EN
        ,
        .PerfStallCnt  (PerfStallCnt),
        .PerfFlushCnt  (PerfFlushCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          xfers    = 0;
    int          epoch    = 0;
    int          cyc_now  = 0;
    logic [31:0] mpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    function automatic int live_outstanding();
        int n;
        n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
        return n;
    endfunction

    // Monitor: pops the scoreboard whenever decode actually accepts an instruction.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && InstrValid && InstrReady && !RedirectValid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_instr: got InstrPC %h expected no valid entry", InstrPC);
            end else begin
                e = sbq.pop_front();
                xfers++;
                chk("Instr",   Instr,   e.instr);
                chk("InstrPC", InstrPC, e.pc);
                chk("PCPlus8", PCPlus8, e.pc + 32'd8);
            end
        end
    end

    initial begin
        logic [31:0] redir_tbl [5];
        int          gnt_pct, rdy_pct, rsp_pct, red_pct, max_lat, mode;
        logic        exp_req, exp_vld;
        mreq_t       m;

        redir_tbl[0] = 32'h0000_0100;
        redir_tbl[1] = 32'h0000_0103;
        redir_tbl[2] = 32'hFFFF_FFF4;
        redir_tbl[3] = 32'hFFFF_FFFE;
        redir_tbl[4] = 32'h0000_2000;

        reset = 1'b1; ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = '0;
        RedirectValid = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        mpc = RST_PC;
`ifdef FETCH_PERF_EN
        exp_stall = '0; exp_flush = '0;
`endif

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc_now = c;
            mode = (c / 300) % 5;
            case (mode)
                0:       begin gnt_pct = 100; rdy_pct = 100; rsp_pct = 100; red_pct = 0;  max_lat = 1; end
                1:       begin gnt_pct = 70;  rdy_pct = 10;  rsp_pct = 80;  red_pct = 0;  max_lat = 3; end
                2:       begin gnt_pct = 80;  rdy_pct = 70;  rsp_pct = 80;  red_pct = 8;  max_lat = 3; end
                3:       begin gnt_pct = 50;  rdy_pct = 50;  rsp_pct = 60;  red_pct = 15; max_lat = 2; end
                default: begin gnt_pct = 90;  rdy_pct = 90;  rsp_pct = 90;  red_pct = 30; max_lat = 1; end
            endcase

            reset         = (c < 2) || (c == 1500) || (c == 2401);
            ImemGnt       = ($urandom_range(99) < gnt_pct);
            InstrReady    = ($urandom_range(99) < rdy_pct);
            RedirectValid = !reset && ($urandom_range(99) < red_pct);
            RedirectPC    = ($urandom_range(3) == 0) ? $urandom() : redir_tbl[$urandom_range(4)];
            ImemRValid    = !reset && (mem_q.size() > 0) && (mem_q[0].due <= c)
                            && ($urandom_range(99) < rsp_pct);
            ImemRData     = ImemRValid ? mem_q[0].data : $urandom();
            #1;

            exp_vld = !reset && (sbq.size() > 0);
            exp_req = !reset && !RedirectValid && ((live_outstanding() + sbq.size()) < DEPTH);
            chk("InstrValid", 32'(InstrValid), 32'(exp_vld));
            chk("ImemReq",    32'(ImemReq),    32'(exp_req));
            if (exp_req) chk("ImemAddr", ImemAddr, mpc);
`ifdef FETCH_PERF_EN
            chk("PerfStallCnt", PerfStallCnt, exp_stall);
            chk("PerfFlushCnt", PerfFlushCnt, exp_flush);
            if (reset) begin
                exp_stall = '0;
                exp_flush = '0;
            end else begin
                if (exp_vld && !InstrReady && exp_stall != 32'hFFFF_FFFF) exp_stall++;
                if (RedirectValid && exp_flush != 32'hFFFF_FFFF) exp_flush++;
            end
`endif

            if (reset) begin
                // Memory is reset alongside the unit, so nothing old comes back.
                mem_q.delete();
                sbq.delete();
                mpc = RST_PC;
                epoch++;
                continue;
            end
            if (ImemRValid) begin
                m = mem_q.pop_front();
                if (!RedirectValid && m.epoch == epoch) sbq.push_back('{m.data, m.addr});
            end
            if (RedirectValid) begin
                epoch++;
                sbq.delete();
                mpc = RedirectPC & ~32'd3;
            end else if (exp_req && ImemGnt) begin
                m.addr  = mpc;
                m.data  = (mode == 0) ? mpc : $urandom();
                m.epoch = epoch;
                m.due   = c + $urandom_range(max_lat, 1);
                mem_q.push_back(m);
                mpc = mpc + 32'd4;
            end
        end

        @(negedge clk);
        #3;
        checks++;
        if (xfers < 200) begin
            failures++;
            $display("FAIL throughput: got %0d transfers expected at least 200", xfers);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
